spi_reg_bank: RTL and testbench
===============================

# spi_reg_bank

Parametrised SPI slave (mode 0) that sits between the external SPI pins and the fabric, replacing fixed two-register front ends with a configurable bank of NUM_REGS write registers, per-register read-back sources, and an auto-incrementing memory burst-read mode. All SPI pins are oversampled in the `clk` domain. Every frame starts with a command byte, during which a status byte is returned. The command byte is followed by either one DATA_W-bit register word or a stream of MEM_W-bit memory words.

## Interface
- DATA_W, 32: register word width (8..64).
- NUM_REGS, 4: number of registers (1..64).
- MEM_W, 16: memory word width (8..32).
- MEM_AW, 12: memory address width (1..MEM_W).
- MEM_LAT, 2: `clk` cycles from `mem_addr` change to valid `mem_data` (1..4).
- STATUS_ID, 4'hA: upper nibble of the status byte.
- `clk`  in  1  system clock; everything is clocked on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sck`  in  1  SPI clock, asynchronous to `clk`, CPOL=0.
- `mosi`  in  1  SPI data in, asynchronous.
- `ncs`  in  1  SPI chip select, active low, asynchronous.
- `miso`  out  1  SPI data out, MSB first, registered.
- `q`  out  NUM_REGS*DATA_W  register contents; register i is `q[i*DATA_W +: DATA_W]`.
- `wr_stb`  out  NUM_REGS  one-`clk` pulse on bit i in the cycle register i updates.
- `data_in`  in  NUM_REGS*DATA_W  read-back source for register i, same slicing as `q`.
- `mem_addr`  out  MEM_AW  burst read address, registered.
- `mem_rd`  out  1  one-`clk` pulse whenever `mem_addr` is updated.
- `mem_data`  in  MEM_W  memory data, valid MEM_LAT cycles after `mem_addr`.

## Operation
- Synchronisers: `sck`, `mosi` and `ncs` each pass through 2 flops, plus one history flop for edge detection.
  - Bits are sampled on the synchronised `sck` rising edge.
  - `miso` updates on the synchronised `sck` falling edge.
- Command byte: bit 7 = WR, bit 6 = MEM, bits 5:0 = IDX.
- FSM states: IDLE, CMD, REG, MADDR, MDATA.
- IDLE -> CMD on synchronised `ncs` falling edge.
  - The status shift register is loaded.
  - The status MSB goes to `miso` in the same cycle.
- CMD: runs for 8 rising edges.
  - On the 8th edge, go to MADDR if MEM=1, otherwise to REG.
  - On entry to REG, the read word is loaded: `data_in` slice IDX if IDX < NUM_REGS, else 0.
- REG: shifts DATA_W bits.
  - On the DATA_W-th rising edge, if WR=1 and IDX < NUM_REGS, `q` slice IDX takes the received word and `wr_stb[IDX]` pulses in the next cycle.
  - Further edges are ignored and `miso` = 0 until `ncs` rises.
- MADDR: shifts MEM_W bits; `miso` = 0 throughout.
  - On the last edge, `mem_addr` takes the low MEM_AW received bits, `mem_rd` pulses, and the state goes to MDATA.
- MDATA: `mem_data` is captured MEM_LAT cycles after each `mem_rd` into the next-word buffer.
  - At each word boundary (falling edge after the MEM_W-th rising edge), the buffer is moved into the shift register.
  - `mem_addr` is incremented, wrapping at 2^MEM_AW - 1 -> 0, and `mem_rd` pulses.
  - The burst is unbounded; WR is ignored in MEM mode.
- Synchronised `ncs` rising edge in any state -> IDLE.
  - A partially received register word is discarded: no write, no `wr_stb`.
  - `miso` is driven to 0.
- Status byte = {STATUS_ID, last_ok, last_bad_idx, 2'b01}.
  - last_ok = the previous frame completed its CMD and data word (REG), or reached MDATA (MEM).
  - last_bad_idx = the previous frame used IDX >= NUM_REGS in REG mode.
  - Both flags update on `ncs` rising.
- Reset: all of the following are 0.
  - `q`, `wr_stb`, `miso`, `mem_addr`, `mem_rd`.
  - last_ok, last_bad_idx.
  - The FSM is forced to IDLE; this applies mid-frame too.
- Reset released mid-frame: wait for a fresh `ncs` falling edge.

## Timing
- Input-to-internal latency: 3 `clk` cycles.
- Required SPI timing:
  - `sck` high ≥ 4 `clk` and low ≥ 4 `clk`.
  - `ncs` low to first `sck` rise ≥ 4 `clk`.
  - Last `sck` fall to `ncs` rise ≥ 4 `clk`.
- MEM mode: `sck` low ≥ MEM_LAT + 5 `clk`, so the next-word buffer is valid before the boundary load.
- `miso` is valid within 4 `clk` of the `sck` falling edge, so it is stable before the next rising edge.
- `q` update: 4 `clk` after the last data `sck` rise; `wr_stb` follows 1 cycle later.

## Test plan
- Reset then read: reset; frame with cmd 0x00 and `data_in` slice 0 = 0x24AF55AA -> status 0xA1, data 0x24AF55AA, `q` = 0, no `wr_stb`.
- Write: cmd 0x81, data 0x01234567 -> `q` slice 1 = 0x01234567, `wr_stb` = 4'b0010 for exactly one cycle. Next frame status = 0xA9.
- Aborted write: cmd 0x82, `ncs` raised after 20 data bits -> `q` slice 2 unchanged, no `wr_stb`. Next status = 0xA1.
- Invalid index: cmd 0x85 with NUM_REGS=4, data 0xFFFFFFFF -> read word 0, `q` unchanged. Next status = 0xAD.
- Memory burst, with `mem_data` = {4'hE, mem_addr} and MEM_LAT=2: cmd 0x40, address word 0x0FFE, then 4 words -> 0xEFFE, 0xEFFF, 0xE000, 0xE001 (wrap), with 5 `mem_rd` pulses.
- Reset mid-frame: assert `rst` during bit 10 of a write -> all outputs 0 immediately; the remainder of the frame is ignored; a clean following frame works normally.

Source files
------------

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave with a register bank and an auto-incrementing memory burst read.
// Every frame is a command byte, which returns a status byte, followed by one register word or a stream of memory words.
module spi_reg_bank #(
  parameter int         DATA_W    = 32,
  parameter int         NUM_REGS  = 4,
  parameter int         MEM_W     = 16,
  parameter int         MEM_AW    = 12,
  parameter int         MEM_LAT   = 2,
  parameter logic [3:0] STATUS_ID = 4'hA
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sck,
  input  logic                         mosi,
  input  logic                         ncs,
  output logic                         miso,
  output logic [NUM_REGS*DATA_W-1:0]   q,
  output logic [NUM_REGS-1:0]          wr_stb,
  input  logic [NUM_REGS*DATA_W-1:0]   data_in,
  output logic [MEM_AW-1:0]            mem_addr,
  output logic                         mem_rd,
  input  logic [MEM_W-1:0]             mem_data
);
  localparam int SH_W = (DATA_W > MEM_W) ? DATA_W : MEM_W;

  typedef enum logic [2:0] {IDLE, CMD, REG, MADDR, MDATA} state_t;
  state_t state_q, state_d;

  // [0],[1] synchronise, [2] is the edge-detect history.
  // ncs resets low so that a frame already in progress at reset release is not mistaken for a new start.
  logic [2:0] sck_q, ncs_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q  <= '0;
      ncs_q  <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ncs_q  <= {ncs_q[1:0], ncs};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  logic sck_rise, sck_fall, ncs_rise, ncs_fall;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ncs_rise = ncs_q[1] & ~ncs_q[2];
  assign ncs_fall = ~ncs_q[1] & ncs_q[2];

  logic [6:0]        cnt_q;
  logic [SH_W-2:0]   rx_q;
  logic [SH_W-1:0]   rx_word;
  logic [SH_W-1:0]   tx_q;
  logic              miso_q;
  logic              cmd_wr_q;
  logic [5:0]        cmd_idx_q;
  logic              idx_ok_q;
  logic              done_q;
  logic              late_q;
  logic              frame_ok_q, frame_bad_q;
  logic              last_ok_q, last_bad_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic [MEM_LAT-1:0] rd_pipe_q;
  logic [MEM_W-1:0]  buf_q;
  logic              wr_hit_q;

  logic              last_reg, last_mem, new_idx_ok, wr_now, mem_cap, rd_busy;
  logic [DATA_W-1:0] rd_word;
  logic [MEM_W-1:0]  next_word;
  logic [7:0]        status;

  assign rx_word    = {rx_q, mosi_q[1]};
  assign last_reg   = (cnt_q == 7'(DATA_W - 1));
  assign last_mem   = (cnt_q == 7'(MEM_W - 1));
  assign new_idx_ok = ({1'b0, rx_word[5:0]} < 7'(NUM_REGS));
  assign status     = {STATUS_ID, last_ok_q, last_bad_q, 2'b01};
  assign mem_cap    = rd_pipe_q[MEM_LAT-1];
  assign rd_busy    = mem_rd_q | (|rd_pipe_q);
  assign next_word  = mem_cap ? mem_data : buf_q;
  assign wr_now     = (state_q == REG) && sck_rise && !done_q && last_reg &&
                      cmd_wr_q && idx_ok_q && !ncs_rise;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rx_word[5:0] == 6'(i)) rd_word = data_in[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ncs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ncs_fall) state_d = CMD;
        CMD:     if (sck_rise && cnt_q == 7'd7) state_d = rx_word[6] ? MADDR : REG;
        MADDR:   if (sck_rise && last_mem) state_d = MDATA;
        default: ;
      endcase
    end
  end

  // Each memory read returns MEM_LAT cycles after its mem_rd pulse; this pipe marks the capture cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe_q <= '0;
      buf_q     <= '0;
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe_q[i] <= rd_pipe_q[i-1];
      rd_pipe_q[0] <= mem_rd_q;
      if (mem_cap) buf_q <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_idx_q   <= '0;
      idx_ok_q    <= 1'b0;
      done_q      <= 1'b0;
      late_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_bad_q <= 1'b0;
      last_ok_q   <= 1'b0;
      last_bad_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      wr_hit_q    <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      wr_hit_q <= wr_now;
      if (ncs_rise) begin
        miso_q <= 1'b0;
        cnt_q  <= '0;
        done_q <= 1'b0;
        late_q <= 1'b0;
        if (state_q != IDLE) begin
          last_ok_q  <= frame_ok_q;
          last_bad_q <= frame_bad_q;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (ncs_fall) begin
              miso_q      <= status[7];
              tx_q        <= SH_W'(status) << (SH_W - 7);
              cnt_q       <= '0;
              done_q      <= 1'b0;
              frame_ok_q  <= 1'b0;
              frame_bad_q <= 1'b0;
            end
          end
          CMD: begin
            if (sck_rise) begin
              rx_q  <= rx_word[SH_W-2:0];
              cnt_q <= cnt_q + 7'd1;
              if (cnt_q == 7'd7) begin
                cnt_q     <= '0;
                cmd_wr_q  <= rx_word[7];
                cmd_idx_q <= rx_word[5:0];
                idx_ok_q  <= new_idx_ok;
                if (rx_word[6]) begin
                  tx_q <= '0;
                end else begin
                  tx_q        <= SH_W'(rd_word) << (SH_W - DATA_W);
                  frame_bad_q <= !new_idx_ok;
                end
              end
            end
            if (sck_fall) begin
              miso_q <= tx_q[SH_W-1];
              tx_q   <= tx_q << 1;
            end
          end
          REG: begin
            if (sck_rise && !done_q) begin
              rx_q  <= rx_word[SH_W-2:0];
              cnt_q <= cnt_q + 7'd1;
              if (last_reg) begin
                cnt_q      <= '0;
                done_q     <= 1'b1;
                frame_ok_q <= 1'b1;
              end
            end
            if (sck_fall) begin
              miso_q <= done_q ? 1'b0 : tx_q[SH_W-1];
              tx_q   <= tx_q << 1;
            end
          end
          MADDR: begin
            if (sck_rise) begin
              rx_q  <= rx_word[SH_W-2:0];
              cnt_q <= cnt_q + 7'd1;
              if (last_mem) begin
                cnt_q      <= '0;
                mem_addr_q <= rx_word[MEM_AW-1:0];
                mem_rd_q   <= 1'b1;
                done_q     <= 1'b1;
                frame_ok_q <= 1'b1;
              end
            end
            if (sck_fall) miso_q <= 1'b0;
          end
          MDATA: begin
            if (sck_rise) begin
              cnt_q <= cnt_q + 7'd1;
              if (last_mem) begin
                cnt_q  <= '0;
                done_q <= 1'b1;
              end
            end
            // A boundary that beat the first read's data is completed when that data arrives.
            if (late_q && mem_cap) begin
              late_q <= 1'b0;
              miso_q <= mem_data[MEM_W-1];
              tx_q   <= SH_W'(mem_data) << (SH_W - MEM_W + 1);
            end
            if (sck_fall) begin
              if (done_q) begin
                done_q     <= 1'b0;
                mem_addr_q <= mem_addr_q + 1'b1;
                mem_rd_q   <= 1'b1;
                if (mem_cap || !rd_busy) begin
                  miso_q <= next_word[MEM_W-1];
                  tx_q   <= SH_W'(next_word) << (SH_W - MEM_W + 1);
                end else begin
                  late_q <= 1'b1;
                end
              end else begin
                miso_q <= tx_q[SH_W-1];
                tx_q   <= tx_q << 1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_q;
      logic              stb_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          reg_q <= '0;
          stb_q <= 1'b0;
        end else begin
          stb_q <= wr_hit_q && (cmd_idx_q == 6'(gi));
          if (wr_now && cmd_idx_q == 6'(gi)) reg_q <= rx_word[DATA_W-1:0];
        end
      end
      assign q[gi*DATA_W +: DATA_W] = reg_q;
      assign wr_stb[gi]             = stb_q;
    end
  endgenerate

  assign miso     = miso_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: register read/write, abort, bad index, memory burst with wrap, and mid-frame reset.
module tb_spi_reg_bank;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sck, mosi, ncs;
  logic         miso;
  logic [127:0] q;
  logic [3:0]   wr_stb;
  logic [127:0] data_in;
  logic [11:0]  mem_addr;
  logic         mem_rd;
  logic [15:0]  mem_data;
  logic [15:0]  mem_p1, mem_p2;

  int checks = 0;
  int errors = 0;
  int stb_cnt [4] = '{0, 0, 0, 0};
  int rd_cnt = 0;

  spi_reg_bank dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ncs(ncs), .miso(miso),
    .q(q), .wr_stb(wr_stb), .data_in(data_in),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Memory with two cycles of latency returning {4'hE, address}.
  always @(posedge clk) begin
    mem_p1 <= {4'hE, mem_addr};
    mem_p2 <= mem_p1;
  end
  assign mem_data = mem_p2;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (wr_stb[i]) stb_cnt[i]++;
    if (mem_rd) rd_cnt++;
  end

  task automatic spi_shift(input int n, input logic [63:0] dout, input bit fall_last,
                           output logic [63:0] din);
    din = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = dout[i];
      repeat (HALF) @(negedge clk);
      din = {din[62:0], miso};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i > 0 || fall_last) sck = 1'b0;
    end
  endtask

  task automatic frame_end();
    if (sck) sck = 1'b0;
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; ncs = 1'b1;
    data_in = {32'h0BADF00D, 32'h2468ACE0, 32'h13579BDF, 32'h24AF55AA};
    repeat (4) @(negedge clk);
    checks++; if (q !== 128'h0) begin errors++; $display("FAIL reset_q: got %h expected 0", q); end
    checks++; if (wr_stb !== 4'b0) begin errors++; $display("FAIL reset_wr_stb: got %b expected 0000", wr_stb); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
    checks++; if (mem_addr !== 12'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 000", mem_addr); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    $display("reset done");
  endtask

  task automatic test_read();
    logic [63:0] st, d;
    int s1 [4];
    for (int i = 0; i < 4; i++) s1[i] = stb_cnt[i];
    ncs = 1'b0;
    spi_shift(8, 64'h00, 1'b1, st);
    spi_shift(32, 64'h0, 1'b1, d);
    frame_end();
    $display("read  cmd=00 status=%h data=%h", st[7:0], d[31:0]);
    checks++; if (st[7:0] !== 8'hA1) begin errors++; $display("FAIL read_status: got %h expected a1", st[7:0]); end
    checks++; if (d[31:0] !== 32'h24AF55AA) begin errors++; $display("FAIL read_data: got %h expected 24af55aa", d[31:0]); end
    checks++; if (q !== 128'h0) begin errors++; $display("FAIL read_q: got %h expected 0", q); end
    checks++;
    if (stb_cnt[0] != s1[0] || stb_cnt[1] != s1[1] || stb_cnt[2] != s1[2] || stb_cnt[3] != s1[3]) begin
      errors++; $display("FAIL read_wr_stb: got strobe activity expected none");
    end
  endtask

  task automatic test_write();
    logic [63:0] st, d;
    int s1 [4];
    for (int i = 0; i < 4; i++) s1[i] = stb_cnt[i];
    ncs = 1'b0;
    spi_shift(8, 64'h81, 1'b1, st);
    spi_shift(32, 64'h01234567, 1'b1, d);
    frame_end();
    $display("write cmd=81 status=%h data=%h", st[7:0], d[31:0]);
    checks++; if (st[7:0] !== 8'hA9) begin errors++; $display("FAIL write_status: got %h expected a9", st[7:0]); end
    checks++; if (d[31:0] !== 32'h13579BDF) begin errors++; $display("FAIL write_readback: got %h expected 13579bdf", d[31:0]); end
    checks++; if (q !== {64'h0, 32'h01234567, 32'h0}) begin errors++; $display("FAIL write_q: got %h expected slice1=01234567", q); end
    checks++; if (stb_cnt[1] - s1[1] != 1) begin errors++; $display("FAIL write_stb1: got %0d cycles expected 1", stb_cnt[1] - s1[1]); end
    checks++;
    if (stb_cnt[0] != s1[0] || stb_cnt[2] != s1[2] || stb_cnt[3] != s1[3]) begin
      errors++; $display("FAIL write_stb_other: got strobe on another bit expected none");
    end
  endtask

  task automatic test_abort();
    logic [63:0] st, d;
    int s1 [4];
    for (int i = 0; i < 4; i++) s1[i] = stb_cnt[i];
    ncs = 1'b0;
    spi_shift(8, 64'h82, 1'b1, st);
    spi_shift(20, 64'hABCDE, 1'b1, d);
    frame_end();
    $display("abort cmd=82 status=%h after 20 bits", st[7:0]);
    checks++; if (st[7:0] !== 8'hA9) begin errors++; $display("FAIL abort_status: got %h expected a9", st[7:0]); end
    checks++; if (q !== {64'h0, 32'h01234567, 32'h0}) begin errors++; $display("FAIL abort_q: got %h expected unchanged", q); end
    checks++;
    if (stb_cnt[0] != s1[0] || stb_cnt[1] != s1[1] || stb_cnt[2] != s1[2] || stb_cnt[3] != s1[3]) begin
      errors++; $display("FAIL abort_wr_stb: got strobe activity expected none");
    end
  endtask

  task automatic test_invalid_idx();
    logic [63:0] st, d;
    int s1 [4];
    for (int i = 0; i < 4; i++) s1[i] = stb_cnt[i];
    ncs = 1'b0;
    spi_shift(8, 64'h85, 1'b1, st);
    spi_shift(32, 64'hFFFFFFFF, 1'b1, d);
    frame_end();
    $display("badix cmd=85 status=%h data=%h", st[7:0], d[31:0]);
    checks++; if (st[7:0] !== 8'hA1) begin errors++; $display("FAIL badidx_status: got %h expected a1", st[7:0]); end
    checks++; if (d[31:0] !== 32'h0) begin errors++; $display("FAIL badidx_data: got %h expected 00000000", d[31:0]); end
    checks++; if (q !== {64'h0, 32'h01234567, 32'h0}) begin errors++; $display("FAIL badidx_q: got %h expected unchanged", q); end
    checks++;
    if (stb_cnt[0] != s1[0] || stb_cnt[1] != s1[1] || stb_cnt[2] != s1[2] || stb_cnt[3] != s1[3]) begin
      errors++; $display("FAIL badidx_wr_stb: got strobe activity expected none");
    end
  endtask

  task automatic test_mem_burst();
    logic [63:0] st, d;
    logic [15:0] exp_w [4] = '{16'hEFFE, 16'hEFFF, 16'hE000, 16'hE001};
    int r0;
    r0 = rd_cnt;
    ncs = 1'b0;
    spi_shift(8, 64'h40, 1'b1, st);
    checks++; if (st[7:0] !== 8'hAD) begin errors++; $display("FAIL mem_status: got %h expected ad", st[7:0]); end
    spi_shift(16, 64'h0FFE, 1'b1, d);
    checks++; if (d[15:0] !== 16'h0) begin errors++; $display("FAIL mem_addr_phase_miso: got %h expected 0000", d[15:0]); end
    for (int w = 0; w < 4; w++) begin
      spi_shift(16, 64'h0, (w < 3), d);
      $display("burst word %0d data=%h", w, d[15:0]);
      checks++; if (d[15:0] !== exp_w[w]) begin errors++; $display("FAIL mem_word%0d: got %h expected %h", w, d[15:0], exp_w[w]); end
    end
    // Counted before the trailing sck fall, which would start the next word.
    checks++; if (rd_cnt - r0 != 5) begin errors++; $display("FAIL mem_rd_pulses: got %0d expected 5", rd_cnt - r0); end
    checks++; if (mem_addr !== 12'h002) begin errors++; $display("FAIL mem_addr_final: got %h expected 002", mem_addr); end
    frame_end();
  endtask

  task automatic test_reset_mid();
    logic [63:0] st, d;
    logic [63:0] word;
    int s1 [4];
    word = 64'hDEADBEEF;
    ncs = 1'b0;
    spi_shift(8, 64'h83, 1'b1, st);
    spi_shift(10, word >> 22, 1'b0, d);
    rst = 1'b1;
    #1;
    checks++; if (q !== 128'h0) begin errors++; $display("FAIL midrst_q: got %h expected 0", q); end
    checks++; if (wr_stb !== 4'b0) begin errors++; $display("FAIL midrst_wr_stb: got %b expected 0000", wr_stb); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL midrst_miso: got %b expected 0", miso); end
    checks++; if (mem_addr !== 12'h0) begin errors++; $display("FAIL midrst_mem_addr: got %h expected 000", mem_addr); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL midrst_mem_rd: got %b expected 0", mem_rd); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) s1[i] = stb_cnt[i];
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
    spi_shift(22, word, 1'b1, d);
    frame_end();
    $display("midrst frame remainder sent, q=%h", q);
    checks++; if (q !== 128'h0) begin errors++; $display("FAIL midrst_ignored_q: got %h expected 0", q); end
    checks++; if (stb_cnt[3] != s1[3]) begin errors++; $display("FAIL midrst_ignored_stb: got strobe expected none"); end
    ncs = 1'b0;
    spi_shift(8, 64'h83, 1'b1, st);
    spi_shift(32, word, 1'b1, d);
    frame_end();
    $display("write cmd=83 status=%h data=%h", st[7:0], d[31:0]);
    checks++; if (st[7:0] !== 8'hA1) begin errors++; $display("FAIL clean_status: got %h expected a1", st[7:0]); end
    checks++; if (d[31:0] !== 32'h0BADF00D) begin errors++; $display("FAIL clean_readback: got %h expected 0badf00d", d[31:0]); end
    checks++; if (q !== {32'hDEADBEEF, 96'h0}) begin errors++; $display("FAIL clean_q: got %h expected slice3=deadbeef", q); end
    checks++; if (stb_cnt[3] - s1[3] != 1) begin errors++; $display("FAIL clean_stb3: got %0d cycles expected 1", stb_cnt[3] - s1[3]); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_abort();
    test_invalid_idx();
    test_mem_burst();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
